// File: rtl/norm_ctrl_pkg.sv
// Shared types and constants for the crop-filter -> normalizer frame sequencer.
//   ctrl_state_t     : sequencer states
//   DEFAULT_NORM_DEN : denominator value out of reset
//   MIN_NORM_DEN     : smallest legal denominator (a zero divisor is replaced by this)
//   clamp_den()      : maps a zero denominator candidate onto MIN_NORM_DEN
package norm_ctrl_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_CF,
    WAIT_NR,
    DONE,
    ERROR
  } ctrl_state_t;

  localparam logic [PIX_W-1:0] DEFAULT_NORM_DEN = 8'd255;
  localparam logic [PIX_W-1:0] MIN_NORM_DEN     = 8'd1;

  // The normalizer divides by this value, so zero is never allowed through.
  function automatic logic [PIX_W-1:0] clamp_den(input logic [PIX_W-1:0] value);
    return (value == '0) ? MIN_NORM_DEN : value;
  endfunction

endpackage

// File: rtl/norm_pipeline_ctrl_watchdog_timer.sv
// Per-wait-state watchdog.
//   clk, s_axis_resetn : clock, async active-low reset
//   restart            : clears the count (first cycle of a new wait state follows)
//   enable             : high in every cycle spent in a watched wait state
//   expired            : registered; high in the LIMIT-th consecutive enabled cycle
module watchdog_timer #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic s_axis_resetn,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(LIMIT - 2);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // count holds the number of enabled cycles already completed; expired is
  // raised one edge early so it lines up with the LIMIT-th cycle itself.
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (restart) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable) begin
      if (count != LAST) count <= count + CNT_W'(1);
      expired <= (count >= PRE_LAST);
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/norm_pipeline_ctrl.sv
// Per-frame sequencer for the crop-filter -> normalizer path.
//   clk, s_axis_resetn          : clock, async active-low reset
//   frame_req                   : one-cycle frame request (one-deep queue behind it)
//   seq_ap_idle                 : upstream sequencer idle
//   cf_ap_ready/done, cf_max_pixel : crop filter handshake and per-frame maximum
//   nr_ap_ready/done            : normalizer handshake
//   norm_mode, cfg_norm_value   : auto (captured max) or static denominator select
//   err_clear                   : leaves the sticky watchdog error
//   cf_ap_start, nr_ap_start    : paired one-cycle start pulses
//   norm_denominator            : denominator presented to the normalizer
//   busy, frame_done, frame_count, drop_count, timeout_err : status
module norm_pipeline_ctrl
  import norm_ctrl_pkg::*;
#(
  parameter int unsigned OUT_ROWS       = 10,
  parameter int unsigned OUT_COLS       = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned FCNT_W         = 16
) (
  input  logic              clk,
  input  logic              s_axis_resetn,
  input  logic              frame_req,
  input  logic              seq_ap_idle,
  input  logic              cf_ap_ready,
  input  logic              cf_ap_done,
  input  logic [PIX_W-1:0]  cf_max_pixel,
  input  logic              nr_ap_ready,
  input  logic              nr_ap_done,
  input  logic              norm_mode,
  input  logic [PIX_W-1:0]  cfg_norm_value,
  input  logic              err_clear,
  output logic              cf_ap_start,
  output logic              nr_ap_start,
  output logic [PIX_W-1:0]  norm_denominator,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_count,
  output logic [FCNT_W-1:0] drop_count,
  output logic              timeout_err
);

  // Elaboration-time parameter sanity.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if ((OUT_ROWS == 0) || (OUT_COLS == 0)) begin : g_bad_geometry
    $error("OUT_ROWS and OUT_COLS must be non-zero");
  end

  ctrl_state_t      state, next_state;
  logic             pending, pending_d;
  logic             start_q, start_d;
  logic [PIX_W-1:0] den_q, den_d;
  logic             frame_done_d;
  logic             drop_inc;
  logic             accept;
  logic             wd_restart, wd_enable, wd_expired;

  assign cf_ap_start      = start_q;
  assign nr_ap_start      = start_q;
  assign norm_denominator = den_q;

  assign accept     = (state == IDLE) && (frame_req || pending) && seq_ap_idle;
  assign wd_enable  = (state == WAIT_CF) || (state == WAIT_NR);
  assign wd_restart = (next_state != state) &&
                      ((next_state == WAIT_CF) || (next_state == WAIT_NR));

  watchdog_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk           (clk),
    .s_axis_resetn (s_axis_resetn),
    .restart       (wd_restart),
    .enable        (wd_enable),
    .expired       (wd_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) state <= IDLE;
    else                state <= next_state;
  end

  // Next-state logic. LAUNCH is left only after its start pulse has been out
  // for a cycle, so the pulse is always exactly one cycle wide.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = LAUNCH;
      LAUNCH:  if (start_q) next_state = WAIT_CF;
      WAIT_CF: begin
        if (cf_ap_done)      next_state = nr_ap_done ? DONE : WAIT_NR;
        else if (wd_expired) next_state = ERROR;
      end
      WAIT_NR: begin
        if (nr_ap_done)      next_state = DONE;
        else if (wd_expired) next_state = ERROR;
      end
      DONE:    next_state = IDLE;
      ERROR:   if (err_clear) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / bookkeeping next values.
  always_comb begin
    start_d      = 1'b0;
    den_d        = den_q;
    frame_done_d = 1'b0;
    pending_d    = pending;
    drop_inc     = 1'b0;

    start_d      = (state == LAUNCH) && !start_q && cf_ap_ready && nr_ap_ready;
    frame_done_d = (state == DONE);

    if ((state == WAIT_CF) && cf_ap_done)
      den_d = clamp_den(norm_mode ? cf_max_pixel : cfg_norm_value);

    // One-deep request queue; a request arriving as the pending one is
    // consumed refills the slot instead of being dropped.
    if (state == ERROR) begin
      if (frame_req) drop_inc  = 1'b1;
      if (err_clear) pending_d = 1'b0;
    end else if (accept) begin
      if (pending) pending_d = frame_req;
    end else if (frame_req) begin
      if (pending) drop_inc  = 1'b1;
      else         pending_d = 1'b1;
    end
  end

  // Registered outputs and bookkeeping.
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      start_q     <= 1'b0;
      den_q       <= DEFAULT_NORM_DEN;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
      pending     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      start_q     <= start_d;
      den_q       <= den_d;
      busy        <= (next_state != IDLE);
      frame_done  <= frame_done_d;
      pending     <= pending_d;
      timeout_err <= (next_state == ERROR);
      if (frame_done_d) frame_count <= frame_count + FCNT_W'(1);
      if (drop_inc)     drop_count  <= drop_count + FCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_norm_pipeline_ctrl.sv
// Bench for norm_pipeline_ctrl: directed frames, a behavioural reference
// checked every cycle, and literal expectations at key points.
module tb_norm_pipeline_ctrl;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_req = 1'b0;
  logic        seq_ap_idle = 1'b1;
  logic        cf_ap_ready = 1'b1;
  logic        cf_ap_done = 1'b0;
  logic [7:0]  cf_max_pixel = 8'd0;
  logic        nr_ap_ready = 1'b1;
  logic        nr_ap_done = 1'b0;
  logic        norm_mode = 1'b1;
  logic [7:0]  cfg_norm_value = 8'd0;
  logic        err_clear = 1'b0;
  logic        cf_ap_start, nr_ap_start;
  logic [7:0]  norm_denominator;
  logic        busy, frame_done, timeout_err;
  logic [15:0] frame_count, drop_count;

  int total = 0;
  int bad   = 0;
  int cf_pulses = 0;
  int nr_pulses = 0;

  norm_pipeline_ctrl #(
    .OUT_ROWS       (10),
    .OUT_COLS       (10),
    .TIMEOUT_CYCLES (TO),
    .FCNT_W         (16)
  ) dut (
    .clk              (clk),
    .s_axis_resetn    (rst_n),
    .frame_req        (frame_req),
    .seq_ap_idle      (seq_ap_idle),
    .cf_ap_ready      (cf_ap_ready),
    .cf_ap_done       (cf_ap_done),
    .cf_max_pixel     (cf_max_pixel),
    .nr_ap_ready      (nr_ap_ready),
    .nr_ap_done       (nr_ap_done),
    .norm_mode        (norm_mode),
    .cfg_norm_value   (cfg_norm_value),
    .err_clear        (err_clear),
    .cf_ap_start      (cf_ap_start),
    .nr_ap_start      (nr_ap_start),
    .norm_denominator (norm_denominator),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_count      (frame_count),
    .drop_count       (drop_count),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases of a frame's life, stepped once per clock.
  localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_WCF = 2, PH_WNR = 3, PH_DONE = 4, PH_ERR = 5;
  int          m_ph = PH_IDLE;
  int          m_nph;
  int          m_wait = 0;
  bit          m_pend = 0;
  bit          m_fired = 0;
  bit          m_accept;
  logic        e_start = 1'b0;
  logic        e_done = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_terr = 1'b0;
  logic [7:0]  e_den = 8'd255;
  logic [15:0] e_fcnt = '0;
  logic [15:0] e_dcnt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = PH_IDLE; m_wait = 0; m_pend = 0; m_fired = 0;
      e_start = 0; e_done = 0; e_busy = 0; e_terr = 0;
      e_den = 8'd255; e_fcnt = '0; e_dcnt = '0;
    end else begin
      m_nph    = m_ph;
      e_start  = 0;
      e_done   = 0;
      m_accept = (m_ph == PH_IDLE) && (frame_req || m_pend) && seq_ap_idle;

      if (m_ph == PH_ERR) begin
        if (frame_req) e_dcnt = e_dcnt + 16'd1;
        if (err_clear) m_pend = 0;
      end else if (m_accept) begin
        if (m_pend) m_pend = frame_req;
      end else if (frame_req) begin
        if (m_pend) e_dcnt = e_dcnt + 16'd1;
        else        m_pend = 1;
      end

      case (m_ph)
        PH_IDLE:   if (m_accept) m_nph = PH_LAUNCH;
        PH_LAUNCH: begin
          if (m_fired) m_nph = PH_WCF;
          else if (cf_ap_ready && nr_ap_ready) e_start = 1;
        end
        PH_WCF: begin
          m_wait++;
          if (cf_ap_done) begin
            e_den = norm_mode ? cf_max_pixel : cfg_norm_value;
            if (e_den == 8'd0) e_den = 8'd1;
            m_nph = nr_ap_done ? PH_DONE : PH_WNR;
          end else if (m_wait >= TO) m_nph = PH_ERR;
        end
        PH_WNR: begin
          m_wait++;
          if (nr_ap_done) m_nph = PH_DONE;
          else if (m_wait >= TO) m_nph = PH_ERR;
        end
        PH_DONE: begin
          e_done = 1;
          e_fcnt = e_fcnt + 16'd1;
          m_nph  = PH_IDLE;
        end
        PH_ERR:  if (err_clear) m_nph = PH_IDLE;
        default: m_nph = PH_IDLE;
      endcase

      m_fired = e_start;
      if (m_nph != m_ph) m_wait = 0;
      m_ph   = m_nph;
      e_busy = (m_nph != PH_IDLE);
      e_terr = (m_nph == PH_ERR);
    end
  end

  // Every-cycle comparison against the model, plus start pulse tallies.
  always @(negedge clk) begin
    check("cf_ap_start", cf_ap_start, e_start);
    check("nr_ap_start", nr_ap_start, e_start);
    check("norm_denominator", norm_denominator, e_den);
    check("busy", busy, e_busy);
    check("frame_done", frame_done, e_done);
    check("frame_count", frame_count, e_fcnt);
    check("drop_count", drop_count, e_dcnt);
    check("timeout_err", timeout_err, e_terr);
    if (cf_ap_start) cf_pulses++;
    if (nr_ap_start) nr_pulses++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_req_pulse();
    frame_req = 1'b1; @(negedge clk); frame_req = 1'b0;
  endtask

  task automatic cf_done_pulse(input logic [7:0] px);
    cf_ap_done = 1'b1; cf_max_pixel = px; @(negedge clk); cf_ap_done = 1'b0;
  endtask

  task automatic nr_done_pulse();
    nr_ap_done = 1'b1; @(negedge clk); nr_ap_done = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (cf_ap_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cf_ap_start !== 1'b1) check("start_wait_timeout", 0, 1);
  endtask

  task automatic finish_frame(input logic [7:0] px);
    wait_start();
    step(1);
    cf_done_pulse(px);
    step(1);
    nr_done_pulse();
    step(2);
  endtask

  task automatic reset_and_check_literals(input string tag);
    check({tag, "_den"}, norm_denominator, 255);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fcnt"}, frame_count, 0);
    check({tag, "_dcnt"}, drop_count, 0);
    check({tag, "_terr"}, timeout_err, 0);
    check({tag, "_cf_start"}, cf_ap_start, 0);
    check({tag, "_nr_start"}, nr_ap_start, 0);
    check({tag, "_fdone"}, frame_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    step(2);
    reset_and_check_literals("reset");
    rst_n = 1'b1;
    step(1);

    // Nominal frame, auto mode.
    cf_pulses = 0; nr_pulses = 0;
    frame_req_pulse();
    @(negedge clk);
    check("nom_start_cycle2_cf", cf_ap_start, 1);
    check("nom_start_cycle2_nr", nr_ap_start, 1);
    step(2);
    cf_done_pulse(8'd200);
    check("nom_den", norm_denominator, 200);
    step(1);
    nr_done_pulse();
    @(negedge clk);
    check("nom_frame_done", frame_done, 1);
    check("nom_frame_count", frame_count, 1);
    step(1);
    check("nom_cf_pulses", cf_pulses, 1);
    check("nom_nr_pulses", nr_pulses, 1);

    // Zero maximum in auto mode, then static mode.
    frame_req_pulse();
    finish_frame(8'd0);
    check("zero_max_den", norm_denominator, 1);
    norm_mode = 1'b0; cfg_norm_value = 8'd50;
    frame_req_pulse();
    finish_frame(8'd123);
    check("static_den", norm_denominator, 50);
    check("static_fcnt", frame_count, 3);
    norm_mode = 1'b1;

    // Back-pressure from the normalizer.
    nr_ap_ready = 1'b0;
    cf_pulses = 0; nr_pulses = 0;
    frame_req_pulse();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_no_start", cf_ap_start, 0);
    end
    nr_ap_ready = 1'b1;
    finish_frame(8'd9);
    check("bp_cf_pulses", cf_pulses, 1);
    check("bp_nr_pulses", nr_pulses, 1);
    check("bp_den", norm_denominator, 9);

    // Queueing: one pending, two dropped.
    frame_req_pulse();
    wait_start();
    step(1);
    frame_req_pulse();
    step(1);
    frame_req_pulse();
    step(1);
    frame_req_pulse();
    cf_done_pulse(8'd10);
    step(1);
    nr_done_pulse();
    finish_frame(8'd11);
    check("queue_drops", drop_count, 2);
    check("queue_fcnt", frame_count, 6);
    check("queue_den", norm_denominator, 11);

    // Watchdog expiry in WAIT_CF.
    frame_req_pulse();
    wait_start();
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk);
      check("wd_not_yet", timeout_err, 0);
    end
    @(negedge clk);
    check("wd_expired", timeout_err, 1);
    cf_done_pulse(8'd99);
    nr_done_pulse();
    frame_req_pulse();
    step(1);
    check("err_hold_terr", timeout_err, 1);
    check("err_hold_den", norm_denominator, 11);
    check("err_hold_fcnt", frame_count, 6);
    check("err_drop", drop_count, 3);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("clear_terr", timeout_err, 0);
    check("clear_busy", busy, 0);

    // Asynchronous reset while waiting on the normalizer.
    frame_req_pulse();
    wait_start();
    step(1);
    cf_done_pulse(8'd77);
    check("pre_reset_den", norm_denominator, 77);
    step(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_and_check_literals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    frame_req_pulse();
    finish_frame(8'd200);
    check("post_reset_fcnt", frame_count, 1);
    check("post_reset_den", norm_denominator, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
